// File: rtl/execute.sv
// MIPS execute stage: ALU, beq/bne/j resolution, wrong-path squash and the EX/MEM register.
// A taken transfer raises a one-cycle redirect and bubbles the next SQUASH instructions.
module execute #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned SQUASH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             DX_MemtoReg,
    input  logic             DX_RegWrite,
    input  logic             DX_MemRead,
    input  logic             DX_MemWrite,
    input  logic             DX_branch,
    input  logic             DX_jump,
    input  logic [2:0]       DX_ALUctr,
    input  logic [WIDTH-1:0] DX_A,
    input  logic [WIDTH-1:0] DX_B,
    input  logic [WIDTH-1:0] DX_MD,
    input  logic [15:0]      DX_imm,
    input  logic [WIDTH-1:0] DX_NPC,
    input  logic [WIDTH-1:0] DX_JT,
    input  logic [4:0]       DX_RD,
    output logic             XM_MemtoReg,
    output logic             XM_RegWrite,
    output logic             XM_MemRead,
    output logic             XM_MemWrite,
    output logic [WIDTH-1:0] XM_ALUout,
    output logic [WIDTH-1:0] XM_MD,
    output logic [4:0]       XM_RD,
    output logic             XM_Taken,
    output logic [WIDTH-1:0] XM_Target
);

    localparam int unsigned CNT_W = 2;
    localparam int unsigned IMM_W = 16;

    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] w_alu;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_bt;
    logic [WIDTH-1:0] w_target;
    logic             w_kill;
    logic             w_take_br;
    logic             w_take_j;
    logic             w_take;

    assign w_diff = DX_A - DX_B;

    // ALU; compare ops reuse the subtractor so the result is A-B
    always_comb begin
        w_alu = '0;
        case (DX_ALUctr)
            3'd0:    w_alu = DX_A + DX_B;
            3'd1:    w_alu = w_diff;
            3'd2:    w_alu = DX_A & DX_B;
            3'd3:    w_alu = DX_A | DX_B;
            3'd4:    w_alu = WIDTH'($signed(DX_A) < $signed(DX_B));
            3'd5:    w_alu = w_diff;
            3'd6:    w_alu = w_diff;
            default: w_alu = '0;
        endcase
    end

    assign w_bt      = DX_NPC + {{(WIDTH-IMM_W-2){DX_imm[IMM_W-1]}}, DX_imm, 2'b00};
    assign w_kill    = (r_cnt != '0);
    assign w_take_br = ~w_kill & DX_branch &
                       (((DX_ALUctr == 3'd5) & (DX_A == DX_B)) |
                        ((DX_ALUctr == 3'd6) & (DX_A != DX_B)));
    assign w_take_j  = ~w_kill & DX_jump;
    assign w_take    = w_take_br | w_take_j;
    assign w_target  = w_take_j ? DX_JT : w_bt;

    // Squash counter plus EX/MEM register; killed slots become bubbles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            XM_MemtoReg <= 1'b0;
            XM_RegWrite <= 1'b0;
            XM_MemRead  <= 1'b0;
            XM_MemWrite <= 1'b0;
            XM_ALUout   <= '0;
            XM_MD       <= '0;
            XM_RD       <= '0;
            XM_Taken    <= 1'b0;
            XM_Target   <= '0;
        end else begin
            if (w_take)
                r_cnt <= CNT_W'(SQUASH);
            else if (w_kill)
                r_cnt <= r_cnt - CNT_W'(1);

            XM_MemtoReg <= DX_MemtoReg & ~w_kill;
            XM_RegWrite <= DX_RegWrite & ~w_kill;
            XM_MemRead  <= DX_MemRead  & ~w_kill;
            XM_MemWrite <= DX_MemWrite & ~w_kill;
            XM_RD       <= w_kill ? 5'd0 : DX_RD;
            XM_ALUout   <= w_alu;
            XM_MD       <= DX_MD;
            XM_Taken    <= w_take;
            XM_Target   <= w_target;
        end
    end

endmodule

// File: tb/tb_execute.sv
// Scoreboard bench for the execute stage: expectations are queued as stimulus is
// applied and popped when the EX/MEM register shows the result one edge later.
module tb_execute;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        DX_MemtoReg, DX_RegWrite, DX_MemRead, DX_MemWrite, DX_branch, DX_jump;
    logic [2:0]  DX_ALUctr;
    logic [31:0] DX_A, DX_B, DX_MD, DX_NPC, DX_JT;
    logic [15:0] DX_imm;
    logic [4:0]  DX_RD;
    logic        XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite, XM_Taken;
    logic [31:0] XM_ALUout, XM_MD, XM_Target;
    logic [4:0]  XM_RD;

    execute #(.WIDTH(32), .SQUASH(2)) dut (
        .clk(clk), .rst(rst),
        .DX_MemtoReg(DX_MemtoReg), .DX_RegWrite(DX_RegWrite),
        .DX_MemRead(DX_MemRead), .DX_MemWrite(DX_MemWrite),
        .DX_branch(DX_branch), .DX_jump(DX_jump), .DX_ALUctr(DX_ALUctr),
        .DX_A(DX_A), .DX_B(DX_B), .DX_MD(DX_MD), .DX_imm(DX_imm),
        .DX_NPC(DX_NPC), .DX_JT(DX_JT), .DX_RD(DX_RD),
        .XM_MemtoReg(XM_MemtoReg), .XM_RegWrite(XM_RegWrite),
        .XM_MemRead(XM_MemRead), .XM_MemWrite(XM_MemWrite),
        .XM_ALUout(XM_ALUout), .XM_MD(XM_MD), .XM_RD(XM_RD),
        .XM_Taken(XM_Taken), .XM_Target(XM_Target)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        m2r, rw, mr, mw, br, j;
        logic [2:0]  op;
        logic [31:0] a, b, md, npc, jt;
        logic [15:0] imm;
        logic [4:0]  rd;
    } in_t;

    typedef struct {
        logic        m2r, rw, mr, mw, tk;
        logic [31:0] alu, md, tgt;
        logic [4:0]  rd;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   m_cnt  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic in_t mk(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd, input logic rw);
        in_t t;
        t = '{m2r: 1'b0, rw: rw, mr: 1'b0, mw: 1'b0, br: 1'b0, j: 1'b0, op: op,
              a: a, b: b, md: 32'hCAFE_0000 | 32'(rd), npc: 32'h1000, jt: 32'h0,
              imm: 16'h0004, rd: rd};
        return t;
    endfunction

    // Reference behaviour of one instruction, advancing the bench's squash count
    function automatic exp_t model(input in_t t);
        exp_t        e;
        logic [31:0] alu, bt;
        logic        kill, tk;
        case (t.op)
            3'd0:    alu = t.a + t.b;
            3'd1:    alu = t.a - t.b;
            3'd2:    alu = t.a & t.b;
            3'd3:    alu = t.a | t.b;
            3'd4:    alu = ($signed(t.a) < $signed(t.b)) ? 32'd1 : 32'd0;
            3'd5:    alu = t.a - t.b;
            3'd6:    alu = t.a - t.b;
            default: alu = 32'd0;
        endcase
        bt   = t.npc + (32'($signed(t.imm)) << 2);
        kill = (m_cnt != 0);
        tk   = !kill && (t.j || (t.br && ((t.op == 3'd5 && t.a == t.b) ||
                                          (t.op == 3'd6 && t.a != t.b))));
        e.m2r = t.m2r && !kill;
        e.rw  = t.rw  && !kill;
        e.mr  = t.mr  && !kill;
        e.mw  = t.mw  && !kill;
        e.rd  = kill ? 5'd0 : t.rd;
        e.tk  = tk;
        e.alu = alu;
        e.md  = t.md;
        e.tgt = (!kill && t.j) ? t.jt : bt;
        m_cnt = tk ? 2 : (kill ? m_cnt - 1 : 0);
        return e;
    endfunction

    task automatic drive(input in_t t);
        DX_MemtoReg = t.m2r; DX_RegWrite = t.rw; DX_MemRead = t.mr; DX_MemWrite = t.mw;
        DX_branch = t.br; DX_jump = t.j; DX_ALUctr = t.op;
        DX_A = t.a; DX_B = t.b; DX_MD = t.md; DX_imm = t.imm;
        DX_NPC = t.npc; DX_JT = t.jt; DX_RD = t.rd;
    endtask

    // Drive one instruction, clock it in, compare the popped expectation
    task automatic apply(input in_t t);
        exp_t e;
        drive(t);
        sb.push_back(model(t));
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("m2r", 32'(XM_MemtoReg), 32'(e.m2r));
            check("rw",  32'(XM_RegWrite), 32'(e.rw));
            check("mr",  32'(XM_MemRead),  32'(e.mr));
            check("mw",  32'(XM_MemWrite), 32'(e.mw));
            check("rd",  32'(XM_RD),       32'(e.rd));
            check("tk",  32'(XM_Taken),    32'(e.tk));
            check("alu", XM_ALUout, e.alu);
            check("md",  XM_MD, e.md);
            if (e.tk) check("tgt", XM_Target, e.tgt);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctl"}, 32'({XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite, XM_Taken}), 32'd0);
        check({tag, "_alu"}, XM_ALUout, 32'd0);
        check({tag, "_md"},  XM_MD, 32'd0);
        check({tag, "_rd"},  32'(XM_RD), 32'd0);
        check({tag, "_tgt"}, XM_Target, 32'd0);
    endtask

    in_t t;

    initial begin
        // Reset held with random inputs
        drive(mk(3'($urandom), $urandom, $urandom, 5'($urandom), 1'b1));
        DX_jump = 1'b1; DX_MemWrite = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_zero("rst");
        rst = 1'b0;
        m_cnt = 0;

        apply(mk(3'd0, 32'd5, 32'd7, 5'd3, 1'b1));
        check("add_5_7", XM_ALUout, 32'd12);
        check("add_rd3", 32'(XM_RD), 32'd3);

        // ALU boundary cases
        apply(mk(3'd0, 32'hFFFF_FFFF, 32'd1, 5'd4, 1'b1));
        check("add_wrap", XM_ALUout, 32'd0);
        apply(mk(3'd1, 32'd0, 32'd1, 5'd5, 1'b1));
        check("sub_wrap", XM_ALUout, 32'hFFFF_FFFF);
        apply(mk(3'd4, 32'hFFFF_FFFF, 32'd1, 5'd6, 1'b1));
        check("slt_neg", XM_ALUout, 32'd1);
        apply(mk(3'd4, 32'd1, 32'hFFFF_FFFF, 5'd7, 1'b1));
        check("slt_pos", XM_ALUout, 32'd0);
        apply(mk(3'd2, 32'h0000_F0F0, 32'h0000_FF00, 5'd8, 1'b1));
        check("and", XM_ALUout, 32'h0000_F000);
        apply(mk(3'd3, 32'h0000_F0F0, 32'h0000_FF00, 5'd9, 1'b1));
        check("or", XM_ALUout, 32'h0000_FFF0);
        apply(mk(3'd7, 32'h1234, 32'h5678, 5'd10, 1'b0));
        check("none", XM_ALUout, 32'd0);

        // Taken beq with negative offset, then two squashed adds and a live one
        t = mk(3'd5, 32'd9, 32'd9, 5'd0, 1'b0);
        t.br = 1'b1; t.npc = 32'h100; t.imm = 16'hFFFE;
        apply(t);
        check("beq_tk", 32'(XM_Taken), 32'd1);
        check("beq_tgt", XM_Target, 32'h0000_00F8);
        apply(mk(3'd0, 32'd1, 32'd2, 5'd11, 1'b1));
        check("sq1_rw", 32'(XM_RegWrite), 32'd0);
        check("sq1_tk", 32'(XM_Taken), 32'd0);
        apply(mk(3'd0, 32'd3, 32'd4, 5'd12, 1'b1));
        check("sq2_rd", 32'(XM_RD), 32'd0);
        apply(mk(3'd0, 32'd5, 32'd6, 5'd13, 1'b1));
        check("post_sq_rw", 32'(XM_RegWrite), 32'd1);

        // Not-taken compares leave the pipe alone
        t = mk(3'd6, 32'd4, 32'd4, 5'd0, 1'b0); t.br = 1'b1;
        apply(t);
        check("bne_nt", 32'(XM_Taken), 32'd0);
        t = mk(3'd5, 32'd4, 32'd5, 5'd0, 1'b0); t.br = 1'b1;
        apply(t);
        check("beq_nt", 32'(XM_Taken), 32'd0);
        apply(mk(3'd0, 32'd1, 32'd1, 5'd14, 1'b1));
        check("nt_follow_rw", 32'(XM_RegWrite), 32'd1);

        // Jump; wrong-path beq must not redirect or extend the window
        t = mk(3'd7, 32'd0, 32'd0, 5'd0, 1'b0); t.j = 1'b1; t.jt = 32'h400;
        apply(t);
        check("j_tgt", XM_Target, 32'h0000_0400);
        t = mk(3'd5, 32'd7, 32'd7, 5'd0, 1'b0); t.br = 1'b1;
        apply(t);
        check("wp_beq_tk", 32'(XM_Taken), 32'd0);
        apply(mk(3'd0, 32'd2, 32'd2, 5'd15, 1'b1));
        apply(mk(3'd0, 32'd3, 32'd3, 5'd16, 1'b1));
        check("j_n3_rw", 32'(XM_RegWrite), 32'd1);

        // Jump and branch together: jump target wins
        t = mk(3'd5, 32'd1, 32'd1, 5'd0, 1'b0); t.j = 1'b1; t.br = 1'b1; t.jt = 32'h800;
        apply(t);
        check("jb_tgt", XM_Target, 32'h0000_0800);
        apply(mk(3'd0, 32'd0, 32'd0, 5'd1, 1'b1));
        apply(mk(3'd0, 32'd0, 32'd0, 5'd1, 1'b1));

        // Reset during the kill window, then a store must go through
        t = mk(3'd7, 32'd0, 32'd0, 5'd0, 1'b0); t.j = 1'b1; t.jt = 32'h200;
        apply(t);
        drive(mk(3'd0, 32'd1, 32'd1, 5'd2, 1'b1));
        rst = 1'b1;
        #1;
        check_zero("rst_async");
        m_cnt = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        t = mk(3'd0, 32'h40, 32'h8, 5'd0, 1'b0); t.mw = 1'b1;
        apply(t);
        check("sw_mw", 32'(XM_MemWrite), 32'd1);

        // Random mix including occasional branches and jumps
        for (int i = 0; i < 60; i++) begin
            t = mk(3'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom), 1'($urandom));
            t.m2r = 1'($urandom); t.mr = 1'($urandom); t.mw = 1'($urandom);
            t.md = $urandom; t.npc = $urandom; t.jt = $urandom; t.imm = 16'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                t.br = 1'b1;
                t.op = $urandom_range(0, 1) ? 3'd5 : 3'd6;
                if ($urandom_range(0, 1) == 1) t.b = t.a;
            end
            if ($urandom_range(0, 7) == 0) t.j = 1'b1;
            apply(t);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/execute.md
# execute

Execute stage of the five-stage MIPS pipeline. It sits directly downstream of instruction decode and consumes its registered control, operand and target outputs. It computes the ALU result, resolves beq/bne/j, and registers the result into the EX/MEM pipeline register. It also squashes the two wrong-path instructions that follow a taken control transfer, so that instruction fetch can redirect using its registered redirect outputs.

## Interface
Parameters:
- WIDTH, 32, datapath width; fixed at 32 for this design.
- SQUASH, 2, number of instructions killed after a taken branch or jump.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- DX_MemtoReg, DX_RegWrite, DX_MemRead, DX_MemWrite  in  1 each  control signals from decode.
- DX_branch  in  1  instruction is beq or bne.
- DX_jump  in  1  instruction is j.
- DX_ALUctr  in  3  operation code: 0 add, 1 sub, 2 and, 3 or, 4 slt, 5 beq-compare, 6 bne-compare, 7 none.
- DX_A  in  32  rs value.
- DX_B  in  32  rt value or sign-extended immediate.
- DX_MD  in  32  rt value, used as store data.
- DX_imm  in  16  raw immediate.
- DX_NPC  in  32  PC+4 of the instruction.
- DX_JT  in  32  jump target.
- DX_RD  in  5  destination register.
- XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite  out  1 each  registered control passed to the memory stage.
- XM_ALUout  out  32  registered ALU result.
- XM_MD  out  32  registered store data.
- XM_RD  out  5  registered destination register.
- XM_Taken  out  1  registered; 1 means instruction fetch must load XM_Target on its next edge.
- XM_Target  out  32  registered redirect address.

## Operation
ALU (combinational, result registered into XM_ALUout):
- add: A+B, mod 2^32.
- sub: A−B, mod 2^32; no overflow trap.
- and: A&B.
- or: A|B.
- slt: signed compare; result 1 when A<B, else 0.
- ALUctr 5 or 6: result is A−B.
- ALUctr 7: result is 0.

Branch target:
- BT = DX_NPC + (sign-extended DX_imm << 2), mod 2^32.

Redirect decision (all terms qualified by kill = 0):
- take_br = DX_branch & ((ALUctr==5 & A==B) | (ALUctr==6 & A!=B)).
- take_j = DX_jump.
- Target = DX_JT when take_j, else BT.
- When both DX_jump and DX_branch are set, jump wins.

Squash counter (2-bit state, values 0..SQUASH):
- IDLE (cnt=0) → cnt=SQUASH when take_br|take_j.
- SHADOW (cnt>0) → cnt−1 each edge.
- kill = (cnt != 0).
- While killed, the incoming instruction is converted to a bubble: XM_RegWrite, XM_MemRead, XM_MemWrite, XM_MemtoReg and XM_Taken register 0, and XM_RD registers 0.
- XM_ALUout and XM_MD still register their computed values; these are don't-care for a bubble.
- A branch or jump arriving while kill=1 is wrong-path: it is not taken and does not reload the counter.

Pass-through: XM_MD ← DX_MD and XM_RD ← DX_RD when not killed.

sw and beq/bne carry DX_RegWrite=0 from decode and are propagated unchanged.

## Timing
- Latency: 1 cycle. Inputs sampled at edge N appear on XM_* after edge N.
- XM_Taken is a one-cycle pulse. It is high for exactly the cycle after the edge that sampled the taken instruction.
- Kill window: the next SQUASH edges after a taken edge (N+1 and N+2 for the default).
- rst asserted at any time, including mid-squash: all XM_* outputs go to 0 immediately, and cnt goes to 0.
- First edge after rst deasserts: normal operation with kill=0.
- Back-to-back taken branches: the second branch lies inside the kill window and is ignored. The branch at edge N+3 is evaluated normally.

## Test plan
- Reset: hold rst with random inputs → every XM_* is 0. Release rst; add with A=5, B=7, RD=3 → XM_ALUout=12, XM_RD=3, XM_RegWrite=1, XM_Taken=0.
- ALU edges, one op per cycle:
  - add 0xFFFFFFFF+1 → 0.
  - sub 0−1 → 0xFFFFFFFF.
  - slt A=0xFFFFFFFF, B=1 → 1.
  - slt A=1, B=0xFFFFFFFF → 0.
  - and 0xF0F0, 0xFF00 → 0xF000.
  - or → 0xFFF0.
- beq taken: A=B=9, NPC=0x100, imm=0xFFFE → XM_Taken=1 and XM_Target=0xF8 for one cycle. The next two adds with RegWrite=1 emerge with XM_RegWrite=0 and XM_RD=0. The third add is unaffected.
- bne not taken with A=B; beq not taken with A≠B → XM_Taken=0, no squash, and the following instructions write normally.
- Jump with JT=0x400 → XM_Taken=1, XM_Target=0x400. A taken beq in the next cycle produces XM_Taken=0 and does not extend the window. The instruction at edge N+3 executes.
- Assert rst at edge N+1 of a squash window, then release → cnt cleared, and the first post-reset sw emerges with XM_MemWrite=1.
